// File: rtl/sdram_arbiter_pkg.sv
// Shared types for the SDRAM port arbiter: FSM state encoding and the priority requester index.
// Also holds the index-width helper so N=1 builds still get a 1-bit index.
package sdram_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_READ
  } arb_state_t;

  localparam int ARB_PRIO_REQ = 0;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sdram_arbiter_rr_pick.sv
// Combinational round-robin search over requesters 1..N-1, starting at ptr_i; zero latency.
// No backpressure: found_o simply drops when nobody in 1..N-1 is eligible.
module arb_rr_pick import sdram_arbiter_pkg::*; #(
  parameter int N  = 3,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  eligible_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);

  logic [IW-1:0] cand;

  // Requester 0 is never part of the rotation, so offsets wrap N-1 -> 1.
  function automatic logic [IW-1:0] wrap(input logic [IW-1:0] p, input int k);
    int c;
    c = int'(p) + k;
    if (c > N - 1) c = c - (N - 1);
    return IW'(c);
  endfunction

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    cand    = '0;
    for (int k = 0; k < N - 1; k++) begin
      cand = wrap(ptr_i, k);
      if (!found_o && eligible_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Shares one SDRAM controller port among N requesters; one-cycle grant decision, one transaction in flight.
// Requests wait (req held) until ack; the arbiter stalls indefinitely on a controller that never acks.
module sdram_arbiter import sdram_arbiter_pkg::*; #(
  parameter int N       = 3,
  parameter int AW      = 24,
  parameter int DW      = 16,
  parameter int MAXWAIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N-1:0]          req,
  input  logic [N-1:0]          we,
  input  logic [N-1:0][AW-1:0]  addr,
  input  logic [N-1:0][DW-1:0]  wdata,
  output logic [N-1:0]          ack,
  output logic [N-1:0]          rvalid,
  output logic [DW-1:0]         rdata,
  output logic                  busy,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [AW-1:0]         mem_addr,
  output logic [DW-1:0]         mem_wdata,
  input  logic                  mem_ack,
  input  logic                  mem_rvalid,
  input  logic [DW-1:0]         mem_rdata
);

  localparam int IW = idx_w(N);
  localparam int SW = idx_w(MAXWAIT + 1);

  arb_state_t     state_q, state_d;
  logic [IW-1:0]  grant_q, grant_d;
  logic [IW-1:0]  rr_q, rr_d;
  logic [SW-1:0]  starve_q, starve_d;
  logic           mem_req_q, mem_req_d;
  logic           mem_we_q, mem_we_d;
  logic [AW-1:0]  mem_addr_q, mem_addr_d;
  logic [DW-1:0]  mem_wdata_q, mem_wdata_d;
  logic [N-1:0]   ack_q, ack_d;
  logic [N-1:0]   rvalid_q, rvalid_d;
  logic [DW-1:0]  rdata_q, rdata_d;

  logic [N-1:0]   eligible;
  logic           others;
  logic           take0;
  logic [IW-1:0]  rr_idx;
  logic           rr_found;

  // A requester still sees its own ack this cycle; masking it avoids granting the same request twice.
  assign eligible = req & ~ack_q;
  assign others   = |(eligible & ~(N'(1) << ARB_PRIO_REQ));
  assign take0    = eligible[ARB_PRIO_REQ] && ((starve_q < SW'(MAXWAIT)) || !others);

  arb_rr_pick #(.N(N), .IW(IW)) u_rr_pick (
    .eligible_i (eligible),
    .ptr_i      (rr_q),
    .idx_o      (rr_idx),
    .found_o    (rr_found)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    starve_d    = starve_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    ack_d       = '0;
    rvalid_d    = '0;
    unique case (state_q)
      ARB_IDLE: begin
        if (take0 || rr_found) begin
          grant_d     = take0 ? IW'(ARB_PRIO_REQ) : rr_idx;
          mem_req_d   = 1'b1;
          mem_we_d    = we[grant_d];
          mem_addr_d  = addr[grant_d];
          mem_wdata_d = wdata[grant_d];
          state_d     = ARB_ISSUE;
          if (take0) begin
            // take0 with others pending implies starve_q < MAXWAIT, so this saturates on its own.
            if (others) starve_d = starve_q + SW'(1);
          end else begin
            starve_d = '0;
            rr_d     = (rr_idx == IW'(N - 1)) ? IW'(1) : rr_idx + IW'(1);
          end
        end
      end
      ARB_ISSUE: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          ack_d     = N'(1) << grant_q;
          state_d   = mem_we_q ? ARB_IDLE : ARB_READ;
        end
      end
      ARB_READ: begin
        if (mem_rvalid) begin
          rdata_d  = mem_rdata;
          rvalid_d = N'(1) << grant_q;
          state_d  = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      grant_q     <= '0;
      rr_q        <= IW'(1);
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ack_q       <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_q        <= rr_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ack_q       <= ack_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
    end
  end

  assign ack       = ack_q;
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign busy      = (state_q != ARB_IDLE);
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
